hs_seq_checker: RTL



---
 rtl/hs_seq_checker_pkg.sv | 21 ++
 rtl/hs_lfsr16.sv | 25 ++
 rtl/hs_seq_checker.sv | 104 ++++++++++
 3 files changed

// File: rtl/hs_seq_checker_pkg.sv
// Shared definitions for the sequence-checking sink and the future back-pressured master:
// LFSR constants, sync/track state encoding and a saturating increment.
package hs_seq_checker_pkg;

    // Fibonacci taps 16,14,13,11 expressed on a right-shifting register (bit 0 is tap 16).
    localparam logic [15:0] LFSR_TAP_MASK     = 16'h002D;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    localparam int SAT_W = 32;

    typedef enum logic {
        SEQ_SYNC  = 1'b0,
        SEQ_TRACK = 1'b1
    } seq_state_t;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/hs_lfsr16.sv
// 16-bit Fibonacci LFSR that advances only while enabled; the seed must be non-zero.
module hs_lfsr16
    import hs_seq_checker_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = ^(value & LFSR_TAP_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED;
        end else if (en) begin
            value <= {feedback, value[15:1]};
        end
    end

endmodule

// File: rtl/hs_seq_checker.sv
// Valid/ready sink with optional LFSR back-pressure that checks for an incrementing payload
// sequence and counts accepted beats and sequence errors.
module hs_seq_checker
    import hs_seq_checker_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int          CNT_W     = 16,
    parameter int          BP_MODE   = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err,
    output logic             synced
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] DATA_ONE = WIDTH'(1);

    seq_state_t       state, state_next;
    logic [WIDTH-1:0] expected, expected_next;
    logic [CNT_W-1:0] xfer_cnt_next, err_cnt_next;
    logic             err_next;
    logic [15:0]      lfsr;
    logic             lfsr_unused;
    logic             fire;
    logic             ready_next;

    hs_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .value (lfsr)
    );

    // Only bit 0 gates ready; the upper bits exist for the shared generator.
    assign lfsr_unused = ^lfsr[15:1];

    assign fire       = s_valid & s_ready;
    assign ready_next = en & ((BP_MODE != 0) ? lfsr[0] : 1'b1);
    assign synced     = (state == SEQ_TRACK);

    always_comb begin
        state_next    = state;
        expected_next = expected;
        xfer_cnt_next = xfer_cnt;
        err_cnt_next  = err_cnt;
        err_next      = err;
        if (clr) begin
            state_next    = SEQ_SYNC;
            xfer_cnt_next = '0;
            err_cnt_next  = '0;
            err_next      = 1'b0;
        end else if (fire) begin
            xfer_cnt_next = CNT_W'(sat_inc(SAT_W'(xfer_cnt), SAT_W'(CNT_MAX)));
            case (state)
                SEQ_SYNC: begin
                    expected_next = s_data + DATA_ONE;
                    state_next    = SEQ_TRACK;
                end
                SEQ_TRACK: begin
                    // A mismatch re-arms on the received word so a single drop costs one error.
                    expected_next = s_data + DATA_ONE;
                    if (s_data != expected) begin
                        err_cnt_next = CNT_W'(sat_inc(SAT_W'(err_cnt), SAT_W'(CNT_MAX)));
                        err_next     = 1'b1;
                    end
                end
                default: state_next = SEQ_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEQ_SYNC;
            expected <= '0;
            xfer_cnt <= '0;
            err_cnt  <= '0;
            err      <= 1'b0;
            s_ready  <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_next;
            expected <= expected_next;
            xfer_cnt <= xfer_cnt_next;
            err_cnt  <= err_cnt_next;
            err      <= err_next;
            s_ready  <= ready_next;
            if (fire) begin
                data_out <= s_data;
            end
        end
    end

endmodule
